mdu_ctrl: RTL

- Issue and sequencing controller for the iterative multiply/divide unit (MDU) beside the E stage.
- Accepts one MDU op from E and runs the cycle count for that op.
- Holds a single-entry scoreboard for the MDU destination register and drives stall requests into decode.
- Owns the register-file write port while the MDU result retires; freezes the main pipeline for one cycle if W collides.

---
 rtl/rtoy_mdu_pkg.sv | 20 ++
 rtl/mdu_ctrl_if.sv | 40 ++++
 rtl/mdu_cycle_cnt.sv | 22 ++
 rtl/mdu_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/rtoy_mdu_pkg.sv
// Shared definitions for the MDU issue/sequencing controller:
// FSM state encoding, MDU op codes and default cycle counts.
package rtoy_mdu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_WB   = 2'd2
  } mdu_state_e;

  localparam logic [1:0] OP_MUL  = 2'd0;
  localparam logic [1:0] OP_MULH = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;
  localparam logic [1:0] OP_REM  = 2'd3;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 32;
  localparam int CW_DEF         = 6;

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline <-> MDU controller signal bundle.
// master: pipeline side (decode/E/W drive requests, observe stall/hold/writeback).
// slave : mdu_ctrl.
// Handshake: Start_E is a one-cycle issue strobe that is only legal while the
// controller is idle (MDUBusy=0); there is no ready signal, decode is instead
// held off by Stall_D, and the whole pipeline by PipeHold.
interface mdu_ctrl_if;
  logic       Req_D;
  logic [4:0] RA0_D;
  logic [4:0] RA1_D;
  logic       RS1Used_D;
  logic       RS2Used_D;
  logic [4:0] WA_D;
  logic       WEN_D;
  logic       Start_E;
  logic [1:0] Op_E;
  logic [4:0] WA_E;
  logic       Short_E;
  logic       WEN_W;
  logic       MDUStart;
  logic [1:0] MDUOp;
  logic       MDUBusy;
  logic       Stall_D;
  logic       PipeHold;
  logic       MDUWrite;
  logic [4:0] WA_MDU;
  logic       WEN_MDU;

  modport master (
    output Req_D, RA0_D, RA1_D, RS1Used_D, RS2Used_D, WA_D, WEN_D,
           Start_E, Op_E, WA_E, Short_E, WEN_W,
    input  MDUStart, MDUOp, MDUBusy, Stall_D, PipeHold, MDUWrite, WA_MDU, WEN_MDU
  );

  modport slave (
    input  Req_D, RA0_D, RA1_D, RS1Used_D, RS2Used_D, WA_D, WEN_D,
           Start_E, Op_E, WA_E, Short_E, WEN_W,
    output MDUStart, MDUOp, MDUBusy, Stall_D, PipeHold, MDUWrite, WA_MDU, WEN_MDU
  );
endinterface

// File: rtl/mdu_cycle_cnt.sv
// Loadable down-counter with zero flag; times the BUSY phase of an MDU op.
module mdu_cycle_cnt #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);
  logic [CW-1:0] cnt;

  // Load has priority over decrement; reset clears the count.
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/mdu_ctrl.sv
// MDU issue/sequencing controller: runs the per-op cycle count, keeps a
// single-entry scoreboard for the MDU destination, raises decode stalls and
// owns the register-file write port during the MDU writeback cycle.
// Optional build macro: MDU_EARLY_OUT_EN (short-operand MUL/MULH finish after
// a single BUSY cycle).
module mdu_ctrl
  import rtoy_mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CW         = CW_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  mdu_ctrl_if.slave  ifc,
  output mdu_state_e dbg_state
);
  mdu_state_e    state;
  logic [1:0]    op_q;
  logic [4:0]    wa_q;
  logic          busy_q;
  logic          write_q;
  logic          wen_q;
  logic          issue;
  logic          cnt_zero;
  logic [CW-1:0] load_val;

  assign issue = (state == S_IDLE) && ifc.Start_E;

  // Count to load on issue: N-1 so that BUSY lasts exactly N cycles.
  always_comb begin
    load_val = ifc.Op_E[1] ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
`ifdef MDU_EARLY_OUT_EN
    if (ifc.Short_E && !ifc.Op_E[1]) load_val = '0;
`endif
  end

`ifndef MDU_EARLY_OUT_EN
  logic unused_short;
  assign unused_short = ifc.Short_E;
`endif

  mdu_cycle_cnt #(.CW(CW)) u_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (issue),
    .load_val (load_val),
    .dec      ((state == S_BUSY) && !cnt_zero),
    .zero     (cnt_zero)
  );

  // Sequencing FSM with registered op/destination and writeback controls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      op_q    <= OP_MUL;
      wa_q    <= '0;
      busy_q  <= 1'b0;
      write_q <= 1'b0;
      wen_q   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: if (ifc.Start_E) begin
          state  <= S_BUSY;
          op_q   <= ifc.Op_E;
          wa_q   <= ifc.WA_E;
          busy_q <= 1'b1;
        end
        S_BUSY: if (cnt_zero) begin
          state   <= S_WB;
          write_q <= 1'b1;
          wen_q   <= 1'b0;
        end
        S_WB: begin
          state   <= S_IDLE;
          busy_q  <= 1'b0;
          write_q <= 1'b0;
          wen_q   <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Scoreboard compares: structural, RAW (in flight and being issued), WAW.
  // The in-flight terms cover WB as well since the register file does not
  // forward the value being written.
  always_comb begin
    logic structural, raw_busy, raw_issue, waw;
    structural = ifc.Req_D && (busy_q || ifc.Start_E);
    raw_busy   = busy_q && ((ifc.RS1Used_D && ifc.RA0_D == wa_q) ||
                            (ifc.RS2Used_D && ifc.RA1_D == wa_q));
    raw_issue  = ifc.Start_E && ((ifc.RS1Used_D && ifc.RA0_D == ifc.WA_E) ||
                                 (ifc.RS2Used_D && ifc.RA1_D == ifc.WA_E));
    waw        = !ifc.WEN_D && ((busy_q && ifc.WA_D == wa_q) ||
                                (ifc.Start_E && ifc.WA_D == ifc.WA_E));
    ifc.Stall_D = structural || raw_busy || raw_issue || waw;
  end

  assign ifc.MDUStart = issue;
  assign ifc.MDUOp    = op_q;
  assign ifc.MDUBusy  = busy_q;
  assign ifc.PipeHold = (state == S_WB) && !ifc.WEN_W;
  assign ifc.MDUWrite = write_q;
  assign ifc.WA_MDU   = wa_q;
  assign ifc.WEN_MDU  = wen_q;
  assign dbg_state    = state;
endmodule
